// File: rtl/rram_ctrl_if.sv
// Bundle of command, write-beat, read-beat and array-side signals of the rram_ctrl front-end.
// The controller takes the slave view; the agent driving commands takes the master view.
interface rram_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 4
);
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_we;
    logic [ADDR_W-1:0] i_cmd_adr;
    logic [LEN_W-1:0]  i_cmd_len;
    logic              i_wr_valid;
    logic              o_wr_ready;
    logic [WIDTH-1:0]  i_wr_data;
    logic              o_rd_valid;
    logic              i_rd_ready;
    logic [WIDTH-1:0]  o_rd_data;
    logic              o_rd_last;
    logic              o_busy;
    logic              o_ram_rw_n;
    logic [ADDR_W-1:0] o_ram_adr;
    logic [WIDTH-1:0]  o_ram_data;
    logic [WIDTH-1:0]  i_ram_data;

    modport slave (
        input  i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_len,
        input  i_wr_valid, i_wr_data, i_rd_ready, i_ram_data,
        output o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_data, o_rd_last,
        output o_busy, o_ram_rw_n, o_ram_adr, o_ram_data
    );

    modport master (
        output i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_len,
        output i_wr_valid, i_wr_data, i_rd_ready, i_ram_data,
        input  o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_data, o_rd_last,
        input  o_busy, o_ram_rw_n, o_ram_adr, o_ram_data
    );
endinterface

// File: rtl/rram_ctrl.sv
// Burst command front-end for the single-port rram array: streams write beats in and
// returns read beats through a 2-entry buffer that hides the array's 1-cycle read latency.
module rram_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    rram_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] adr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              issue_done_q;
    logic              in_flight_q;
    logic              in_flight_last_q;
    logic              cmd_ready_q;
    logic              wr_ready_q;
    logic              busy_q;

    logic [WIDTH-1:0]  buf_data_q [0:1];
    logic              buf_last_q [0:1];
    logic              head_q;
    logic              tail_q;
    logic [1:0]        occ_q;

    logic              wr_fire;
    logic              rd_pop;
    logic              rd_issue;
    logic              last_pop;
    logic [2:0]        fill;

    // The array has no enable, so a write only happens on a real beat handshake outside reset.
    assign wr_fire  = bus.i_wr_valid & wr_ready_q & ~rst;
    assign rd_pop   = (occ_q != 2'd0) & bus.i_rd_ready;
    assign fill     = {1'b0, occ_q} + {2'b00, in_flight_q};
    assign rd_issue = (state_q == READ) & ~issue_done_q & (fill < (3'd2 + {2'b00, rd_pop}));
    assign last_pop = rd_pop & buf_last_q[head_q];

    assign bus.o_cmd_ready = cmd_ready_q;
    assign bus.o_wr_ready  = wr_ready_q & ~rst;
    assign bus.o_busy      = busy_q;
    assign bus.o_rd_valid  = (occ_q != 2'd0);
    assign bus.o_rd_data   = buf_data_q[head_q];
    assign bus.o_rd_last   = (occ_q != 2'd0) & buf_last_q[head_q];
    assign bus.o_ram_rw_n  = ~wr_fire;
    assign bus.o_ram_adr   = adr_q;
    assign bus.o_ram_data  = wr_fire ? bus.i_wr_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            adr_q            <= '0;
            cnt_q            <= '0;
            issue_done_q     <= 1'b0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            cmd_ready_q      <= 1'b1;
            wr_ready_q       <= 1'b0;
            busy_q           <= 1'b0;
            head_q           <= 1'b0;
            tail_q           <= 1'b0;
            occ_q            <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
        end else begin
            // Data addressed in the previous cycle arrives now and goes straight into the buffer.
            in_flight_q <= rd_issue;
            if (rd_issue) begin
                in_flight_last_q <= (cnt_q == '0);
            end
            if (in_flight_q) begin
                buf_data_q[tail_q] <= bus.i_ram_data;
                buf_last_q[tail_q] <= in_flight_last_q;
                tail_q             <= ~tail_q;
            end
            if (rd_pop) begin
                head_q <= ~head_q;
            end
            occ_q <= occ_q + {1'b0, in_flight_q} - {1'b0, rd_pop};

            case (state_q)
                IDLE: begin
                    if (bus.i_cmd_valid) begin
                        adr_q        <= bus.i_cmd_adr;
                        cnt_q        <= bus.i_cmd_len;
                        issue_done_q <= 1'b0;
                        state_q      <= bus.i_cmd_we ? WRITE : READ;
                        cmd_ready_q  <= 1'b0;
                        wr_ready_q   <= bus.i_cmd_we;
                        busy_q       <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        if (cnt_q == '0) begin
                            state_q     <= IDLE;
                            cmd_ready_q <= 1'b1;
                            wr_ready_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                            adr_q <= adr_q + ADDR_W'(1);
                        end
                    end
                end
                READ: begin
                    // The address stays on the final beat so the array address holds in IDLE.
                    if (rd_issue) begin
                        if (cnt_q == '0) begin
                            issue_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                            adr_q <= adr_q + ADDR_W'(1);
                        end
                    end
                    if (last_pop) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
